// File: rtl/array_sequencer_if.sv
// rtl/array_sequencer_if.sv - host/buffer handshake bundle for the array run sequencer
interface array_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int W_AW  = 8
);
  logic             i_start;
  logic             i_reuse_w;
  logic [CNT_W-1:0] i_vec_count;
  logic             i_abort;
  logic             o_busy;
  logic             o_done;
  logic             o_through;
  logic             o_w_rd_en;
  logic [W_AW-1:0]  o_w_rd_addr;
  logic             o_x_rd_en;
  logic [CNT_W-1:0] o_x_rd_addr;
  logic             o_out_valid;
  logic [CNT_W-1:0] o_out_addr;

  modport master (
    output i_start, i_reuse_w, i_vec_count, i_abort,
    input  o_busy, o_done, o_through, o_w_rd_en, o_w_rd_addr,
           o_x_rd_en, o_x_rd_addr, o_out_valid, o_out_addr
  );

  modport slave (
    input  i_start, i_reuse_w, i_vec_count, i_abort,
    output o_busy, o_done, o_through, o_w_rd_en, o_w_rd_addr,
           o_x_rd_en, o_x_rd_addr, o_out_valid, o_out_addr
  );
endinterface

// File: rtl/array_sequencer.sv
// rtl/array_sequencer.sv - run controller for the systolic PE array (weight load, feed, result flagging)
module array_sequencer #(
  parameter int ROW_NUMBER    = 256,
  parameter int COLUMN_NUMBER = 256,
  parameter int CNT_W         = 16,
  parameter int ARRAY_LATENCY = ROW_NUMBER + COLUMN_NUMBER - 1,
  parameter int W_AW          = $clog2(ROW_NUMBER)
) (
  input  logic              clk,
  input  logic              rst_n,
  array_sequencer_if.slave  bus
);

  // One extra bit so latency + vec_count never wraps at the maximum count.
  localparam int              CW    = CNT_W + 1;
  localparam logic [CW-1:0]   LAT   = CW'(ARRAY_LATENCY);
  localparam logic [W_AW-1:0] W_TOP = W_AW'(ROW_NUMBER - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_vec;
  logic [W_AW-1:0]  r_w_addr;
  logic             r_busy;
  logic             r_done;
  logic             r_through;
  logic             r_w_rd_en;
  logic             r_x_rd_en;
  logic [CNT_W-1:0] r_x_rd_addr;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_out_addr;

  logic             w_start_ok;
  logic [CW-1:0]    w_vec;
  logic [CW-1:0]    w_cnt;
  logic [CW-1:0]    w_end;
  logic             w_last;
  logic             w_run_next;
  logic             w_x_en;
  logic             w_ov;
  logic [CNT_W-1:0] w_oaddr;

  // w_cnt is the RUN count of the cycle being registered, so the feed and
  // result strobes line up with the count they describe.
  always_comb begin
    w_start_ok = bus.i_start && (bus.i_vec_count != '0);
    w_vec      = (r_state == IDLE) ? {1'b0, bus.i_vec_count} : {1'b0, r_vec};
    w_cnt      = (r_state == RUN) ? (r_cnt + CW'(1)) : '0;
    w_end      = LAT + {1'b0, r_vec} - CW'(1);
    w_last     = (r_state == RUN) && (r_cnt == w_end);
    w_run_next = 1'b0;
    if (!bus.i_abort) begin
      case (r_state)
        IDLE:    w_run_next = w_start_ok && bus.i_reuse_w;
        LOAD_W:  w_run_next = (r_w_addr == '0);
        RUN:     w_run_next = !w_last;
        default: w_run_next = 1'b0;
      endcase
    end
    w_x_en  = (w_cnt < w_vec);
    w_ov    = (w_cnt >= LAT) && (w_cnt < (LAT + w_vec));
    w_oaddr = CNT_W'(w_cnt - LAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_vec       <= '0;
      r_w_addr    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_through   <= 1'b0;
      r_w_rd_en   <= 1'b0;
      r_x_rd_en   <= 1'b0;
      r_x_rd_addr <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.i_abort) begin
        r_state   <= IDLE;
        r_busy    <= 1'b0;
        r_through <= 1'b0;
        r_w_rd_en <= 1'b0;
        r_w_addr  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start_ok) begin
              r_vec  <= bus.i_vec_count;
              r_busy <= 1'b1;
              if (bus.i_reuse_w) begin
                r_state <= RUN;
              end else begin
                r_state   <= LOAD_W;
                r_through <= 1'b1;
                r_w_rd_en <= 1'b1;
                r_w_addr  <= W_TOP;
              end
            end
          end
          // Rows go out top-down so row 0 lands in the top PE row.
          LOAD_W: begin
            if (r_w_addr == '0) begin
              r_state   <= RUN;
              r_through <= 1'b0;
              r_w_rd_en <= 1'b0;
            end else begin
              r_w_addr <= r_w_addr - 1'b1;
            end
          end
          RUN: begin
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
      r_cnt       <= w_run_next ? w_cnt : '0;
      r_x_rd_en   <= w_run_next && w_x_en;
      r_x_rd_addr <= (w_run_next && w_x_en) ? w_cnt[CNT_W-1:0] : '0;
      r_out_valid <= w_run_next && w_ov;
      r_out_addr  <= (w_run_next && w_ov) ? w_oaddr : '0;
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_through   = r_through;
  assign bus.o_w_rd_en   = r_w_rd_en;
  assign bus.o_w_rd_addr = r_w_addr;
  assign bus.o_x_rd_en   = r_x_rd_en;
  assign bus.o_x_rd_addr = r_x_rd_addr;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_out_addr  = r_out_addr;

endmodule

// File: tb/tb_array_sequencer.sv
// tb/tb_array_sequencer.sv - directed bench for array_sequencer on a 4x4 array (latency 7)
module tb_array_sequencer;
  localparam int ROW = 4;
  localparam int COL = 4;
  localparam int CW  = 16;
  localparam int LAT = 7;
  localparam int WA  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  array_sequencer_if #(.CNT_W(CW), .W_AW(WA)) sif();

  array_sequencer #(
    .ROW_NUMBER(ROW), .COLUMN_NUMBER(COL), .CNT_W(CW), .ARRAY_LATENCY(LAT), .W_AW(WA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(sif)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start a run at cycle 0 and check every output on cycles 1..done+1 against the
  // hand-derived timeline; poke>0 re-asserts start (vec 5) during that cycle.
  task automatic run_tl(input string nm, input bit reuse, input int vec, input int poke,
                        output int done_c);
    int s, dc, n_x, n_ov, nxt_oa, last_ov;
    bit e_thr, e_x, e_ov;
    s = reuse ? 1 : ROW + 1;
    dc = s + LAT + vec;
    n_x = 0; n_ov = 0; nxt_oa = 0; last_ov = -1; done_c = -1;
    @(posedge clk); #1;
    sif.i_start = 1'b1; sif.i_reuse_w = reuse; sif.i_vec_count = CW'(vec); sif.i_abort = 1'b0;
    for (int c = 1; c <= dc + 1; c++) begin
      @(posedge clk); #1;
      sif.i_start     = (c == poke);
      sif.i_vec_count = (c == poke) ? CW'(5) : CW'(vec);
      @(negedge clk);
      e_thr = !reuse && c >= 1 && c <= ROW;
      e_x   = c >= s && c < s + vec;
      e_ov  = c >= s + LAT && c < s + LAT + vec;
      chk($sformatf("%s.c%0d.busy", nm, c), sif.o_busy, (c >= 1 && c < dc));
      chk($sformatf("%s.c%0d.done", nm, c), sif.o_done, (c == dc));
      chk($sformatf("%s.c%0d.thr", nm, c), sif.o_through, e_thr);
      chk($sformatf("%s.c%0d.wen", nm, c), sif.o_w_rd_en, e_thr);
      chk($sformatf("%s.c%0d.waddr", nm, c), sif.o_w_rd_addr, e_thr ? ROW - c : 0);
      chk($sformatf("%s.c%0d.xen", nm, c), sif.o_x_rd_en, e_x);
      chk($sformatf("%s.c%0d.xaddr", nm, c), sif.o_x_rd_addr, e_x ? c - s : 0);
      chk($sformatf("%s.c%0d.ov", nm, c), sif.o_out_valid, e_ov);
      if (sif.o_x_rd_en) n_x++;
      if (sif.o_out_valid) begin
        chk($sformatf("%s.c%0d.oaddr", nm, c), sif.o_out_addr, nxt_oa);
        nxt_oa++; n_ov++; last_ov = c;
      end else begin
        chk($sformatf("%s.c%0d.oaddr0", nm, c), sif.o_out_addr, 0);
      end
      if (sif.o_done && done_c < 0) done_c = c;
    end
    chk({nm, ".n_x"}, n_x, vec);
    chk({nm, ".n_ov"}, n_ov, vec);
    chk({nm, ".done_gap"}, done_c - last_ov, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, sif.o_busy, 0);
    chk({tag, ".done"}, sif.o_done, 0);
    chk({tag, ".thr"}, sif.o_through, 0);
    chk({tag, ".wen"}, sif.o_w_rd_en, 0);
    chk({tag, ".xen"}, sif.o_x_rd_en, 0);
    chk({tag, ".ov"}, sif.o_out_valid, 0);
  endtask

  initial begin
    int dcyc;
    bit saw_done;
    sif.i_start = 1'b0; sif.i_reuse_w = 1'b0; sif.i_vec_count = '0; sif.i_abort = 1'b0;
    #12;
    chk_idle("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    run_tl("t1", 1'b0, 3, 0, dcyc);
    chk("t1.done_cycle", dcyc, 15);

    run_tl("t2", 1'b1, 1, 9, dcyc);
    chk("t2.done_cycle", dcyc, 9);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2.start_in_done_ignored", sif.o_busy, 0);

    @(posedge clk); #1;
    sif.i_start = 1'b1; sif.i_reuse_w = 1'b0; sif.i_vec_count = '0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1 sif.i_start = 1'b0;
      @(negedge clk);
      chk($sformatf("t3.c%0d.busy", c), sif.o_busy, 0);
      chk($sformatf("t3.c%0d.thr", c), sif.o_through, 0);
      chk($sformatf("t3.c%0d.done", c), sif.o_done, 0);
    end

    @(posedge clk); #1;
    sif.i_start = 1'b1; sif.i_reuse_w = 1'b1; sif.i_vec_count = CW'(9);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      sif.i_start = 1'b0;
      sif.i_abort = (c == 6);
      @(negedge clk);
      if (c == 6) begin
        chk("t4.pre.busy", sif.o_busy, 1);
        chk("t4.pre.xaddr", sif.o_x_rd_addr, 5);
      end
      if (c == 7) begin
        chk_idle("t4.post");
        chk("t4.post.xaddr", sif.o_x_rd_addr, 0);
      end
    end
    saw_done = 1'b0;
    for (int c = 8; c <= 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (sif.o_done || sif.o_busy) saw_done = 1'b1;
    end
    chk("t4.no_done_after_abort", saw_done, 0);
    @(posedge clk); #1;
    sif.i_start = 1'b1; sif.i_abort = 1'b1; sif.i_reuse_w = 1'b0; sif.i_vec_count = CW'(2);
    @(posedge clk); #1;
    sif.i_start = 1'b0; sif.i_abort = 1'b0;
    @(negedge clk);
    chk("t4.abort_start.busy", sif.o_busy, 0);
    chk("t4.abort_start.wen", sif.o_w_rd_en, 0);
    run_tl("t4b", 1'b1, 1, 0, dcyc);
    chk("t4b.done_cycle", dcyc, 9);

    @(posedge clk); #1;
    sif.i_start = 1'b1; sif.i_reuse_w = 1'b0; sif.i_vec_count = CW'(2);
    @(posedge clk); #1 sif.i_start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5.load.thr", sif.o_through, 1);
    chk("t5.load.waddr", sif.o_w_rd_addr, 2);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("t5.reset");
    chk("t5.reset.waddr", sif.o_w_rd_addr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5.idle.busy", sif.o_busy, 0);
    run_tl("t5b", 1'b0, 2, 3, dcyc);
    chk("t5b.done_cycle", dcyc, 14);

    run_tl("t6", 1'b1, 9, 0, dcyc);
    chk("t6.done_cycle", dcyc, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
